// File: rtl/entropy_src_seed_fifo_pkg.sv
// entropy_src_seed_fifo_pkg
//   Shared definitions for the entropy source seed FIFO: the sparse packer
//   state encodings and a helper that derives the number of words per seed.
//   Also provides a local fallback for CALIPTRA_PRIM_FLOP_SPARSE_FSM (plain
//   async-reset state flop on clk_i/rst_ni) when the prim macro library is
//   not part of the build.

`ifndef CALIPTRA_PRIM_FLOP_SPARSE_FSM
`define CALIPTRA_PRIM_FLOP_SPARSE_FSM(__name, __d, __q, __type, __resval) \
    always_ff @(posedge clk_i or negedge rst_ni) begin : __name \
        if (!rst_ni) __q <= __resval; \
        else         __q <= __d; \
    end
`endif

package entropy_src_seed_fifo_pkg;

    // Pairwise Hamming distance >= 3 so a single upset cannot land on another
    // legal state.
    typedef enum logic [5:0] {
        StIdle  = 6'b001110,
        StPack  = 6'b110101,
        StStall = 6'b101011,
        StError = 6'b010000
    } state_e;

    function automatic int unsigned seed_words(input int unsigned seed_w,
                                               input int unsigned word_w);
        return seed_w / word_w;
    endfunction

    localparam int unsigned SeedWordsDefault = seed_words(384, 32);

endpackage

// File: rtl/entropy_src_seed_fifo_mem.sv
// entropy_src_seed_fifo_mem
//   Circular seed store: Depth entries of Width bits, registered storage,
//   combinational head read. Push is refused when full (current count), pop
//   is ignored when empty, clr_i empties the buffer without touching storage.
//   Optional macro ENTROPY_SRC_SEED_FIFO_PTR_CHK_EN duplicates pointers and
//   count and flags any disagreement or inconsistent count on err_o.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   clr_i                  synchronous flush of pointers and count
//   push_i, wdata_i        write request and data
//   pop_i                  remove head entry
//   rdata_o                head entry
//   full_o, not_empty_o    occupancy flags
//   depth_o                number of stored entries
//   err_o                  pointer/count integrity error

module entropy_src_seed_fifo_mem #(
    parameter int unsigned Width = 385,
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             not_empty_o,
    output logic [CntW-1:0]  depth_o,
    output logic             err_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o      = (cnt_q == CntW'(Depth));
    assign not_empty_o = (cnt_q != '0);
    assign depth_o     = cnt_q;
    assign do_push     = push_i & ~full_o & ~clr_i;
    assign do_pop      = pop_i & not_empty_o & ~clr_i;
    assign rdata_o     = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = ptr_inc(wptr_q);
            if (do_pop)  rptr_d = ptr_inc(rptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < Depth; k++) mem_q[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < Depth; k++) begin
                if (do_push && wptr_q == PtrW'(k)) mem_q[k] <= wdata_i;
            end
        end
    end

`ifdef ENTROPY_SRC_SEED_FIFO_PTR_CHK_EN
    localparam int unsigned SpanW = CntW + 1;

    logic [PtrW-1:0]  wptr_dup_q, rptr_dup_q;
    logic [CntW-1:0]  cnt_dup_q;
    logic [SpanW-1:0] span;
    logic             cnt_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_dup_q <= '0;
            rptr_dup_q <= '0;
            cnt_dup_q  <= '0;
        end else begin
            wptr_dup_q <= wptr_d;
            rptr_dup_q <= rptr_d;
            cnt_dup_q  <= cnt_d;
        end
    end

    // Equal pointers are ambiguous between empty and full; either count is fine.
    always_comb begin
        if (wptr_q >= rptr_q) span = SpanW'(wptr_q) - SpanW'(rptr_q);
        else                  span = SpanW'(wptr_q) + SpanW'(Depth) - SpanW'(rptr_q);
        cnt_ok = (SpanW'(cnt_q) == span) || ((span == '0) && (cnt_q == CntW'(Depth)));
    end

    assign err_o = (wptr_q != wptr_dup_q) | (rptr_q != rptr_dup_q) |
                   (cnt_q != cnt_dup_q) | ~cnt_ok;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/entropy_src_seed_fifo.sv
// entropy_src_seed_fifo
//   Packs WordWidth-bit conditioned entropy words into SeedWidth-bit seeds,
//   ANDs the per-word FIPS flags into a per-seed flag and buffers complete
//   seeds for the downstream ack state machine. Escalation or an illegal
//   state encoding locks the block in a sticky error state until reset.
//   Optional macro ENTROPY_SRC_SEED_FIFO_PTR_CHK_EN enables duplicated FIFO
//   pointer/count checking inside the storage sub-module.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   enable_i                 module enable, low flushes packer and FIFO
//   wvalid_i/wready_o        input word handshake; wdata_i, wfips_i payload
//   not_empty_o, pop_i       seed available / consume head seed
//   rdata_o, rfips_o         head seed (word 0 in bits [31:0]) and its flag
//   depth_o                  number of stored seeds
//   local_escalate_i         force Error
//   err_o                    sticky error

module entropy_src_seed_fifo
    import entropy_src_seed_fifo_pkg::*;
#(
    parameter int unsigned WordWidth = 32,
    parameter int unsigned SeedWidth = 384,
    parameter int unsigned Depth     = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic                         wvalid_i,
    output logic                         wready_o,
    input  logic [WordWidth-1:0]         wdata_i,
    input  logic                         wfips_i,
    output logic                         not_empty_o,
    input  logic                         pop_i,
    output logic [SeedWidth-1:0]         rdata_o,
    output logic                         rfips_o,
    output logic [$clog2(Depth+1)-1:0]   depth_o,
    input  logic                         local_escalate_i,
    output logic                         err_o
);

    localparam int unsigned SeedWords = seed_words(SeedWidth, WordWidth);

    state_e                state_d, state_q;
    logic [3:0]            cnt_d, cnt_q;
    logic                  fips_acc_d, fips_acc_q;
    logic [WordWidth-1:0]  pack_q [SeedWords];
    logic                  slot_we, push, flush;
    logic                  mem_full, mem_not_empty, mem_err;
    logic [SeedWidth-1:0]  seed;
    logic                  seed_fips;

    `CALIPTRA_PRIM_FLOP_SPARSE_FSM(u_state_regs, state_d, state_q, state_e, StIdle)

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fips_acc_d = fips_acc_q;
        wready_o   = 1'b0;
        slot_we    = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;

        case (state_q)
            StIdle: begin
                if (enable_i) state_d = StPack;
            end
            StPack: begin
                wready_o = enable_i;
                slot_we  = wvalid_i & enable_i;
                if (slot_we) begin
                    fips_acc_d = fips_acc_q & wfips_i;
                    if (cnt_q == 4'(SeedWords - 1)) begin
                        if (!mem_full) begin
                            push       = 1'b1;
                            cnt_d      = '0;
                            fips_acc_d = 1'b1;
                        end else begin
                            state_d = StStall;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StStall: begin
                if (!mem_full) begin
                    push       = 1'b1;
                    cnt_d      = '0;
                    fips_acc_d = 1'b1;
                    state_d    = StPack;
                end
            end
            StError: ;
            default: state_d = StError;
        endcase

        if (!enable_i && state_q != StError) begin
            state_d    = StIdle;
            flush      = 1'b1;
            push       = 1'b0;
            cnt_d      = '0;
            fips_acc_d = 1'b1;
        end

        if (local_escalate_i || mem_err) state_d = StError;
    end

    // The final word bypasses the packer registers so a completing seed can
    // be pushed in the same cycle it is accepted.
    always_comb begin
        seed = '0;
        for (int unsigned k = 0; k < SeedWords; k++) begin
            seed[k*WordWidth +: WordWidth] =
                (slot_we && cnt_q == 4'(k)) ? wdata_i : pack_q[k];
        end
        seed_fips = fips_acc_q & (slot_we ? wfips_i : 1'b1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            fips_acc_q <= 1'b1;
            for (int unsigned k = 0; k < SeedWords; k++) pack_q[k] <= '0;
        end else begin
            cnt_q      <= cnt_d;
            fips_acc_q <= fips_acc_d;
            for (int unsigned k = 0; k < SeedWords; k++) begin
                if (slot_we && cnt_q == 4'(k)) pack_q[k] <= wdata_i;
            end
        end
    end

    entropy_src_seed_fifo_mem #(
        .Width (SeedWidth + 1),
        .Depth (Depth)
    ) u_mem (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (flush),
        .push_i      (push),
        .wdata_i     ({seed_fips, seed}),
        .pop_i       (pop_i & (state_q != StError)),
        .rdata_o     ({rfips_o, rdata_o}),
        .full_o      (mem_full),
        .not_empty_o (mem_not_empty),
        .depth_o     (depth_o),
        .err_o       (mem_err)
    );

    assign not_empty_o = mem_not_empty & (state_q != StError);
    assign err_o       = (state_q == StError);

endmodule

// File: tb/tb_entropy_src_seed_fifo.sv
module tb_entropy_src_seed_fifo;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         wvalid;
    logic         wready;
    logic [31:0]  wdata;
    logic         wfips;
    logic         not_empty;
    logic         pop;
    logic [383:0] rdata;
    logic         rfips;
    logic [1:0]   depth;
    logic         esc;
    logic         err;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    entropy_src_seed_fifo #(
        .WordWidth (32),
        .SeedWidth (384),
        .Depth     (2)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .enable_i         (enable),
        .wvalid_i         (wvalid),
        .wready_o         (wready),
        .wdata_i          (wdata),
        .wfips_i          (wfips),
        .not_empty_o      (not_empty),
        .pop_i            (pop),
        .rdata_o          (rdata),
        .rfips_o          (rfips),
        .depth_o          (depth),
        .local_escalate_i (esc),
        .err_o            (err)
    );

    task automatic check(input string tag, input logic [399:0] got, input logic [399:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [383:0] make_seed(input logic [31:0] base);
        logic [383:0] s;
        s = '0;
        for (int k = 0; k < 12; k++) s[k*32 +: 32] = base + 32'(k);
        return s;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic f, input logic with_pop);
        int n;
        n = 0;
        wvalid = 1'b1;
        wdata  = d;
        wfips  = f;
        while (!wready && n < 100) begin
            step();
            n++;
        end
        if (!wready) check("wready_timeout", {399'd0, wready}, 400'd1);
        pop = with_pop;
        step();
        wvalid = 1'b0;
        pop    = 1'b0;
    endtask

    task automatic feed_words(input logic [31:0] base, input int count, input int zero_idx);
        for (int k = 0; k < count; k++) send_word(base + 32'(k), (k != zero_idx), 1'b0);
    endtask

    task automatic pop_once();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        wvalid = 1'b0;
        wdata  = '0;
        wfips  = 1'b0;
        pop    = 1'b0;
        esc    = 1'b0;
        #12;
        check("rst_wready",    {399'd0, wready},    400'd0);
        check("rst_not_empty", {399'd0, not_empty}, 400'd0);
        check("rst_rdata",     {16'd0, rdata},      400'd0);
        check("rst_rfips",     {399'd0, rfips},     400'd0);
        check("rst_depth",     {398'd0, depth},     400'd0);
        check("rst_err",       {399'd0, err},       400'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Idle -> Pack takes one cycle
        enable = 1'b1;
        check("idle_wready", {399'd0, wready}, 400'd0);
        step();
        check("pack_wready", {399'd0, wready}, 400'd1);

        // Basic fill
        feed_words(32'h0, 11, 99);
        check("fill_ne_before", {399'd0, not_empty}, 400'd0);
        send_word(32'hB, 1'b1, 1'b0);
        check("fill_ne",    {399'd0, not_empty},     400'd1);
        check("fill_w0",    {368'd0, rdata[31:0]},   400'h0);
        check("fill_w11",   {368'd0, rdata[383:352]}, 400'hB);
        check("fill_seed",  {16'd0, rdata},          {16'd0, make_seed(32'h0)});
        check("fill_rfips", {399'd0, rfips},         400'd1);
        check("fill_depth", {398'd0, depth},         400'd1);
        pop_once();
        check("pop_depth", {398'd0, depth},     400'd0);
        check("pop_ne",    {399'd0, not_empty}, 400'd0);

        // Pop when empty is ignored
        pop_once();
        check("empty_pop_depth", {398'd0, depth}, 400'd0);
        check("empty_pop_err",   {399'd0, err},   400'd0);

        // FIPS clear on word 5, next seed clean
        feed_words(32'h100, 12, 5);
        check("fips0_rfips", {399'd0, rfips}, 400'd0);
        feed_words(32'h200, 12, 99);
        check("fips_depth2", {398'd0, depth}, 400'd2);
        pop_once();
        check("fips1_rfips", {399'd0, rfips},       400'd1);
        check("fips1_w0",    {368'd0, rdata[31:0]}, 400'h200);

        // Push and pop in the same cycle
        feed_words(32'h300, 11, 99);
        send_word(32'h30B, 1'b1, 1'b1);
        check("pp_depth", {398'd0, depth},       400'd1);
        check("pp_head",  {368'd0, rdata[31:0]}, 400'h300);
        pop_once();
        check("pp_drain", {398'd0, depth}, 400'd0);

        // Full / stall
        feed_words(32'h400, 12, 99);
        feed_words(32'h500, 12, 99);
        feed_words(32'h600, 12, 99);
        check("stall_wready", {399'd0, wready},      400'd0);
        check("stall_depth",  {398'd0, depth},       400'd2);
        check("stall_head",   {368'd0, rdata[31:0]}, 400'h400);
        pop_once();
        check("stall_pop_depth",  {398'd0, depth},       400'd1);
        check("stall_pop_wready", {399'd0, wready},      400'd0);
        check("stall_pop_head",   {368'd0, rdata[31:0]}, 400'h500);
        step();
        check("unstall_depth",  {398'd0, depth},  400'd2);
        check("unstall_wready", {399'd0, wready}, 400'd1);
        pop_once();
        check("held_seed",  {16'd0, rdata},  {16'd0, make_seed(32'h600)});
        check("held_rfips", {399'd0, rfips}, 400'd1);
        pop_once();
        check("stall_drain", {398'd0, depth}, 400'd0);

        // Flush mid-seed
        feed_words(32'h800, 12, 99);
        feed_words(32'h900, 7, 0);
        check("pre_flush_depth", {398'd0, depth}, 400'd1);
        enable = 1'b0;
        step();
        check("flush_depth",  {398'd0, depth},     400'd0);
        check("flush_ne",     {399'd0, not_empty}, 400'd0);
        check("flush_wready", {399'd0, wready},    400'd0);
        enable = 1'b1;
        step();
        feed_words(32'hA00, 12, 99);
        check("reflush_seed",  {16'd0, rdata},  {16'd0, make_seed(32'hA00)});
        check("reflush_rfips", {399'd0, rfips}, 400'd1);
        check("reflush_depth", {398'd0, depth}, 400'd1);

        // Escalation
        check("pre_esc_err", {399'd0, err}, 400'd0);
        esc = 1'b1;
        step();
        esc = 1'b0;
        check("esc_err",    {399'd0, err},       400'd1);
        check("esc_wready", {399'd0, wready},    400'd0);
        check("esc_ne",     {399'd0, not_empty}, 400'd0);
        pop_once();
        check("esc_pop_ignored", {398'd0, depth}, 400'd1);
        step();
        step();
        check("esc_sticky", {399'd0, err}, 400'd1);

`ifdef ENTROPY_SRC_SEED_FIFO_PTR_CHK_EN
        rst_n = 1'b0;
        #3;
        check("chk_rst_err", {399'd0, err}, 400'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        force dut.u_mem.wptr_dup_q = 1'b1;
        step();
        step();
        release dut.u_mem.wptr_dup_q;
        check("ptr_chk_err", {399'd0, err}, 400'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/entropy_src_seed_fifo.md
# entropy_src_seed_fifo

Final seed buffer of the entropy source, directly upstream of the hardware req/ack state machine. It packs 32-bit conditioned entropy words into 384-bit seeds, tags each seed with a FIPS-compliance bit, and stores complete seeds in a small FIFO. The ack state machine consumes seeds through the `not_empty_o`, `pop_i` and `rdata_o` interface. Misuse or internal corruption drives a sticky error and the block stops.

## Interface
- `WordWidth`, 32: input word width.
- `SeedWidth`, 384: seed width; must be an integer multiple of `WordWidth`. `SeedWords = SeedWidth/WordWidth` (12).
- `Depth`, 2: FIFO depth in seeds; must be ≥1.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `enable_i` in 1: module enable; low flushes the block.
- `wvalid_i` in 1: input word valid.
- `wready_o` out 1: input word ready.
- `wdata_i` in WordWidth: entropy word.
- `wfips_i` in 1: FIPS flag of this word.
- `not_empty_o` out 1: at least one complete seed is stored.
- `pop_i` in 1: remove the head seed.
- `rdata_o` out SeedWidth: head seed. Word 0 is in bits [31:0].
- `rfips_o` out 1: FIPS flag of the head seed.
- `depth_o` out $clog2(Depth+1): number of stored seeds.
- `local_escalate_i` in 1: forces the Error state.
- `err_o` out 1: sticky error.

## Operation
- The packer FSM uses sparse encoding and has four states: Idle, Pack, Stall, Error.
  - Idle → Pack when `enable_i` is high.
  - Pack:
    - A word is accepted on `wvalid_i & wready_o`.
    - The word is stored into packer slot `cnt`, and `fips_acc &= wfips_i`.
    - `cnt` is 4 bits and increments modulo `SeedWords`.
    - When the last word is accepted:
      - If the FIFO is not full, the seed and `fips_acc` are written to the FIFO tail, `cnt` → 0, and `fips_acc` → 1. The state stays Pack.
      - If the FIFO is full, the state → Stall and the seed is held in the packer.
  - Stall: `wready_o` is 0. The held seed is written on the first cycle the FIFO is not full, and the state → Pack.
  - Any state with `enable_i` low → Idle.
    - Synchronously clear `cnt`, set `fips_acc` to 1, and empty the FIFO (pointers and count cleared).
    - FIFO contents are invalid after a flush.
  - `local_escalate_i`, or an illegal state encoding, → Error.
    - Error is terminal until reset.
    - In Error: `err_o` = 1, `wready_o` = 0, `not_empty_o` = 0, and pops are ignored.
- `wready_o` = 1 only in Pack with `enable_i` high.
- FIFO:
  - Circular buffer with a registered storage array.
  - `rdata_o` and `rfips_o` are combinational reads of the head entry.
  - A pop when empty is ignored. It does not raise an error.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - The full check for a push uses the current-cycle count. A same-cycle pop does not unblock a push.
  - Pointers wrap at `Depth`.

## Timing
- Reset values:
  - `wready_o` 0.
  - `not_empty_o` 0.
  - `rdata_o` 0 (storage reset to 0).
  - `rfips_o` 0.
  - `depth_o` 0.
  - `err_o` 0.
  - FSM in Idle; `cnt` 0; `fips_acc` 1.
- After reset with `enable_i` high, `wready_o` rises in the cycle after Idle exits.
- Last word accepted in cycle N with the FIFO not full → `not_empty_o` = 1 and `depth_o` incremented in cycle N+1.
- Stall exit: FIFO becomes not full in cycle M → seed written at the end of M, and `wready_o` = 1 in M+1.
- `pop_i` in cycle P → head advances and `depth_o` decrements in cycle P+1.
- `enable_i` low in cycle E → `depth_o` = 0 and `not_empty_o` = 0 in E+1.
- Escalate in cycle X → `err_o` = 1 in X+1.

## Configuration
- `ENTROPY_SRC_SEED_FIFO_PTR_CHK_EN` defined:
  - Read and write pointers and the count are duplicated in independent registers.
  - Any mismatch between copies, or a count different from `wptr - rptr` (mod `Depth`, adjusted for full), forces Error.
- Not defined: no duplicate registers. Error is reached only by escalate or an illegal FSM state.

## Structure
- The package `entropy_src_seed_fifo_pkg` holds:
  - the sparse `state_e` encodings (Idle, Pack, Stall, Error);
  - the `SeedWords` localparam helper.
- The FSM state register is instantiated with `CALIPTRA_PRIM_FLOP_SPARSE_FSM`, reset to Idle.
- One sub-module, `entropy_src_seed_fifo_mem`: a storage array of `Depth` × (SeedWidth+1) bits with pointer/count logic and the optional pointer check. The packer and FSM live in the top module.

## Test plan
- Basic fill:
  - Stimulus: enable; feed words 0x0..0xB, all with FIPS = 1.
  - Response: `not_empty_o` = 1 one cycle after the 12th word; `rdata_o[31:0]` = 0x0 and `rdata_o[383:352]` = 0xB; `rfips_o` = 1; `depth_o` = 1.
- FIPS clear: word 5 has FIPS = 0 → stored seed has `rfips_o` = 0, and the next seed (all FIPS = 1) has `rfips_o` = 1.
- Full/stall:
  - Stimulus: `Depth` = 2; feed 36 words with no pops.
  - Response: after the 3rd seed completes, `wready_o` = 0 and `depth_o` = 2.
  - Pop once → the held seed is written and `depth_o` = 2 again the cycle after; `wready_o` returns to 1.
- Empty pop and simultaneous push/pop:
  - Pop when empty → `depth_o` stays 0.
  - Pop on the cycle the 12th word completes with `depth_o` = 1 → `depth_o` stays 1 and the head advances.
- Flush mid-seed: disable after 7 words → `depth_o` = 0 next cycle. Re-enable and feed 12 words → the seed contains only the new words.
- Error:
  - `local_escalate_i` pulse → `err_o` = 1 next cycle and stays until reset; `wready_o` = 0 and `not_empty_o` = 0.
  - With `ENTROPY_SRC_SEED_FIFO_PTR_CHK_EN`, forcing one duplicate pointer bit → `err_o` = 1.
